gray_updown_counter: RTL and testbench



---
 rtl/gray_updown_counter.sv | 88 ++++++++
 tb/tb_gray_updown_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with synchronous load, wrap pulse
// and an independent registered Gray-to-binary decoder.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   en       - count enable, one step per cycle
//   up       - direction, 1 = increment, 0 = decrement
//   load     - synchronous preset strobe (beats en)
//   load_bin - binary preset value
//   gray_in  - Gray value to decode
//   bin_out  - current binary count
//   gray_out - registered Gray encoding of bin_out
//   wrap     - one-cycle pulse on counter wrap-around
//   dec_out  - registered binary decode of gray_in
module gray_updown_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic [WIDTH-1:0] dec_out
);

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] dec_q, dec_d;

    // Next count and wrap flag; Gray is encoded from the next count so that
    // bin_out and gray_out always update on the same edge.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_bin;
        end else if (en) begin
            if (up) begin
                cnt_d  = cnt_q + ONE;
                wrap_d = &cnt_q;
            end else begin
                cnt_d  = cnt_q - ONE;
                wrap_d = ~|cnt_q;
            end
        end
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        dec_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_d[i] = ^(gray_in >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
            dec_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            dec_q  <= dec_d;
        end
    end

    assign bin_out  = cnt_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign dec_out  = dec_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed self-checking bench for gray_updown_counter.
// Three instances: WIDTH=3/RV=0, WIDTH=4/RV=0, WIDTH=4/RV=9.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_bin3 = '0;
    logic [2:0] gray_in3 = '0;
    logic [3:0] load_bin4 = '0;
    logic [3:0] gray_in4 = '0;

    logic [2:0] bin3, gray3, dec3;
    logic       wrap3;
    logic [3:0] bin4, gray4, dec4;
    logic       wrap4;
    logic [3:0] bin9, gray9, dec9;
    logic       wrap9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(3), .RESET_VALUE(0)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin3), .gray_in(gray_in3),
        .bin_out(bin3), .gray_out(gray3), .wrap(wrap3), .dec_out(dec3)
    );

    gray_updown_counter #(.WIDTH(4), .RESET_VALUE(0)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin4), .gray_in(gray_in4),
        .bin_out(bin4), .gray_out(gray4), .wrap(wrap4), .dec_out(dec4)
    );

    gray_updown_counter #(.WIDTH(4), .RESET_VALUE(9)) u_d9 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin4), .gray_in(gray_in4),
        .bin_out(bin9), .gray_out(gray9), .wrap(wrap9), .dec_out(dec9)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({bin3, gray3, wrap3, dec3} !== 10'b000_000_0_000) begin
            errors++;
            $display("FAIL reset_w3: got %b %b %b %b expected 000 000 0 000",
                     bin3, gray3, wrap3, dec3);
        end
        checks++;
        if ({bin9, gray9, wrap9, dec9} !== 13'b1001_1101_0_0000) begin
            errors++;
            $display("FAIL reset_rv9: got %b %b %b %b expected 1001 1101 0 0000",
                     bin9, gray9, wrap9, dec9);
        end
    endtask

    task automatic test_up_count;
        logic [2:0] exp_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                  3'b111, 3'b101, 3'b100, 3'b000};
        logic [2:0] exp_b [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                                  3'd5, 3'd6, 3'd7, 3'd0};
        logic [2:0] prev;
        do_reset();
        prev = gray3;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (gray3 !== exp_g[i] || bin3 !== exp_b[i] ||
                wrap3 !== (i == 7)) begin
                errors++;
                $display("FAIL up_count[%0d]: got b=%b g=%b w=%b expected b=%b g=%b w=%b",
                         i, bin3, gray3, wrap3, exp_b[i], exp_g[i], (i == 7));
            end
            checks++;
            if ($countones(gray3 ^ prev) != 1) begin
                errors++;
                $display("FAIL one_bit[%0d]: got %b -> %b expected 1 bit change",
                         i, prev, gray3);
            end
            prev = gray3;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap;
        do_reset();
        en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if ({bin3, gray3, wrap3} !== 7'b111_100_1) begin
            errors++;
            $display("FAIL down_wrap: got %b %b %b expected 111 100 1",
                     bin3, gray3, wrap3);
        end
        tick();
        checks++;
        if ({bin3, gray3, wrap3} !== 7'b110_101_0) begin
            errors++;
            $display("FAIL down_after: got %b %b %b expected 110 101 0",
                     bin3, gray3, wrap3);
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority;
        do_reset();
        load = 1'b1; load_bin3 = 3'd5; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({bin3, gray3, wrap3} !== 7'b101_111_0) begin
            errors++;
            $display("FAIL load: got %b %b %b expected 101 111 0",
                     bin3, gray3, wrap3);
        end
        tick();
        checks++;
        if ({bin3, gray3} !== 6'b110_101) begin
            errors++;
            $display("FAIL load_next: got %b %b expected 110 101", bin3, gray3);
        end
        en = 1'b0;
    endtask

    task automatic test_hold_flip;
        do_reset();
        en = 1'b1; up = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bin4, gray4, wrap4} !== 9'b0011_0010_0) begin
                errors++;
                $display("FAIL hold[%0d]: got %b %b %b expected 0011 0010 0",
                         i, bin4, gray4, wrap4);
            end
        end
        en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if ({bin4, gray4} !== 8'b0010_0011) begin
            errors++;
            $display("FAIL flip_down: got %b %b expected 0010 0011", bin4, gray4);
        end
        up = 1'b1;
        tick();
        checks++;
        if ({bin4, gray4} !== 8'b0011_0010) begin
            errors++;
            $display("FAIL flip_up: got %b %b expected 0011 0010", bin4, gray4);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({bin9, gray9, wrap9} !== 9'b1111_1000_0) begin
            errors++;
            $display("FAIL mid_pre: got %b %b %b expected 1111 1000 0",
                     bin9, gray9, wrap9);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        checks++;
        if ({bin9, gray9, wrap9} !== 9'b1001_1101_0) begin
            errors++;
            $display("FAIL mid_reset: got %b %b %b expected 1001 1101 0",
                     bin9, gray9, wrap9);
        end
    endtask

    task automatic test_back_to_back;
        int wraps;
        do_reset();
        wraps = 0;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wrap3) wraps++;
        end
        en = 1'b0;
        checks++;
        if (wraps != 2 || bin3 !== 3'd0) begin
            errors++;
            $display("FAIL b2b_wraps: got %0d wraps bin %0d expected 2 wraps bin 0",
                     wraps, bin3);
        end
    endtask

    task automatic test_decoder;
        logic [3:0] n;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n = 4'(i);
            gray_in4 = n ^ (n >> 1);
            tick();
            checks++;
            if (dec4 !== n) begin
                errors++;
                $display("FAIL decode[%0d]: got %b expected %b", i, dec4, n);
            end
        end
        gray_in4 = 4'b0110;
        tick();
        checks++;
        if (dec4 !== 4'b0100) begin
            errors++;
            $display("FAIL decode_0110: got %b expected 0100", dec4);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_priority();
        test_hold_flip();
        test_reset_mid();
        test_back_to_back();
        test_decoder();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
